// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the shared-adder controller and its arbiter.
package adder_share_ctrl_pkg;

    localparam int ADD_W   = 8;
    // Widest requester index supported (NREQ up to 8).
    localparam int MAX_IDW = 3;

    // One operand beat as presented by a requester.
    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             last;
    } beat_t;

    // One registered result on the response channel.
    typedef struct packed {
        logic [ADD_W-1:0]   sum;
        logic               cout;
        logic [MAX_IDW-1:0] id;
        logic               last;
    } rsp_t;

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin arbiter with lock override: while a chained transaction is in
// flight the owner keeps the grant even if its valid drops.
module adder_rr_arbiter
    import adder_share_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic            lock_i,
    input  logic [IDW-1:0]  owner_i,
    input  logic            advance_i,
    input  logic [IDW-1:0]  adv_idx_i,
    output logic [NREQ-1:0] grant_o,
    output logic            gnt_any_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Pointer moves just past the requester that completed a transaction.
    always_comb begin
        int nxt;
        nxt   = int'(adv_idx_i) + 1;
        ptr_d = ptr_q;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        if (advance_i) begin
            ptr_d = IDW'(nxt);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant: owner when locked, else first valid at or above the pointer with wrap.
    always_comb begin
        int c;
        c         = 0;
        gnt_any_o = 1'b0;
        gnt_idx_o = '0;
        if (lock_i) begin
            gnt_any_o = 1'b1;
            gnt_idx_o = owner_i;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                c = int'(ptr_q) + k;
                if (c >= NREQ) begin
                    c = c - NREQ;
                end
                if (!gnt_any_o && req_valid_i[c]) begin
                    gnt_any_o = 1'b1;
                    gnt_idx_o = IDW'(c);
                end
            end
        end
        grant_o = gnt_any_o ? (NREQ'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one external 8-bit adder among NREQ requesters, chaining carry across
// the beats of a multi-byte transaction and registering each beat's result.
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [ADD_W*NREQ-1:0] req_a,
    input  logic [ADD_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [ADD_W-1:0]      add_a,
    output logic [ADD_W-1:0]      add_b,
    output logic                  add_cin,
    input  logic [ADD_W-1:0]      add_s,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_last
);

    beat_t           beats [NREQ];
    beat_t           sel;
    logic [NREQ-1:0] grant;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic            accept;

    logic            lock_q,      lock_d;
    logic [IDW-1:0]  owner_q,     owner_d;
    logic            carry_q,     carry_d;
    logic            rsp_valid_q, rsp_valid_d;
    rsp_t            rsp_q,       rsp_d;

    adder_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .lock_i      (lock_q),
        .owner_i     (owner_q),
        .advance_i   (accept && sel.last),
        .adv_idx_i   (gnt_idx),
        .grant_o     (grant),
        .gnt_any_o   (gnt_any),
        .gnt_idx_o   (gnt_idx)
    );

    // Unpack requester buses and steer the granted beat onto the adder.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            beats[i].a    = req_a[ADD_W*i +: ADD_W];
            beats[i].b    = req_b[ADD_W*i +: ADD_W];
            beats[i].last = req_last[i];
        end
        sel       = gnt_any ? beats[gnt_idx] : '0;
        add_a     = sel.a;
        add_b     = sel.b;
        add_cin   = lock_q ? carry_q : 1'b0;
        req_ready = grant & {NREQ{!rst && (!rsp_valid_q || rsp_ready)}};
        accept    = |(req_valid & req_ready);
    end

    // Next state: drain, capture, carry chaining and lock/unlock.
    always_comb begin
        lock_d      = lock_q;
        owner_d     = owner_q;
        carry_d     = carry_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_d.sum   = add_s;
            rsp_d.cout  = add_cout;
            rsp_d.id    = MAX_IDW'(gnt_idx);
            rsp_d.last  = sel.last;
            carry_d     = add_cout;
            if (sel.last) begin
                lock_d = 1'b0;
            end else begin
                lock_d  = 1'b1;
                owner_d = gnt_idx;
            end
        end
    end

    // Control and response registers; reset aborts any chain in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q      <= 1'b0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_cout  = rsp_q.cout;
    assign rsp_id    = rsp_q.id[IDW-1:0];
    assign rsp_last  = rsp_q.last;

    if (IDW < MAX_IDW) begin : g_id_trim
        logic unused_id_hi;
        assign unused_id_hi = |rsp_q.id[MAX_IDW-1:IDW];
    end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
Arbitrates and sequences one shared 8-bit ripple adder between NREQ requesters. Each requester issues single-beat or chained multi-beat (multi-byte) additions over a valid/ready handshake. The controller chains carry between beats of one transaction and returns registered results on a single response channel. It sits between requester logic and the adder instance, which lives outside this block and is reached through the add_* ports.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, width of rsp_id; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester beat valid
req_last  input  NREQ  beat is final byte of its transaction
req_a  input  8*NREQ  operand A, requester i at bits [8i+7:8i]
req_b  input  8*NREQ  operand B, same packing
req_ready  output  NREQ  beat accepted when valid&ready
add_a  output  8  to shared adder A
add_b  output  8  to shared adder B
add_cin  output  1  to shared adder carry-in
add_s  input  8  adder sum (combinational from add_*)
add_cout  input  1  adder carry-out
rsp_valid  output  1  response holds a result
rsp_ready  input  1  consumer accepts response
rsp_sum  output  8  registered sum
rsp_cout  output  1  registered carry-out of this beat
rsp_id  output  IDW  requester index that produced it
rsp_last  output  1  copy of req_last of the beat

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_last=0, lock=0, carry_q=0, rr pointer=0. req_ready=0 while rst=1.
- Grant (combinational): if lock=1, grant=owner. Otherwise grant = first i with req_valid[i], searching from the rr pointer upward with wrap. If no request is valid, nothing is granted.
- req_ready[i] = granted(i) && (!rsp_valid || rsp_ready). Only one bit is ever high. A granted requester with req_valid low keeps its grant only while locked.
- Adder drive: add_a/add_b = operands of the granted requester, or 0 if none. add_cin = lock ? carry_q : 0.
- Accept beat (valid&ready on index g): at the next edge rsp_sum<=add_s, rsp_cout<=add_cout, rsp_id<=g, rsp_last<=req_last[g], rsp_valid<=1. Latency: one cycle from accept to rsp_valid.
- carry_q<=add_cout on every accepted beat.
- If req_last=0: lock<=1, owner<=g. If req_last=1: lock<=0, rr pointer<=(g+1) mod NREQ.
- Response drain: rsp_valid&&rsp_ready with no new accept gives rsp_valid<=0. A drain and an accept in the same cycle overwrite the response and keep rsp_valid=1, giving full throughput of one beat per cycle.
- Response registers are stable while rsp_valid=1 and rsp_ready=0.
- While locked, other requesters stall indefinitely. An owner that deasserts valid mid-transaction keeps the lock and carry_q unchanged.
- A single-beat transaction is req_last=1 on its first beat. It uses cin=0 and does not lock.
- An 8-bit sum wraps modulo 256. Overflow is reported only through rsp_cout.
- Reset mid-transaction aborts it: lock and carry clear, the pending response is discarded, and the next beat from any requester starts with cin=0.
- Optional assertions: req_ready is onehot0; rsp_* stable under backpressure.

Decomposition:
- Shared package: beat struct {a[7:0], b[7:0], last}; response struct {sum, cout, id, last}; constant ADD_W=8.
- Natural sub-module: adder_rr_arbiter. It holds the NREQ-way round-robin pointer and produces the onehot grant with lock/owner override. The FSM, carry and response register stay in adder_share_ctrl.
- The controller contains two implicit states, UNLOCKED and LOCKED(owner); no further FSM is required.

Test Plan:
1. Single beat, req0 A=0x7F B=0x01 last=1, rsp_ready=1 -> next cycle rsp_sum=0x80, rsp_cout=0, rsp_id=0, rsp_last=1.
2. Chained 2-beat on req1: beat 1 (0xFF,0x01,last=0), beat 2 (0x00,0x00,last=1) -> responses (0x00, cout=1) then (0x01, cout=0). The second beat is driven with add_cin=1.
3. Contention: req0 and req1 both single-beat valid every cycle from reset -> grants alternate 0,1,0,1, and rsp_id follows one cycle later.
4. Lock: req0 sends a non-last beat, then drops valid for 3 cycles while req1 is valid -> req_ready[1] stays 0. req0 resumes with its last beat, then req1 is granted.
5. Backpressure: rsp_ready=0 with rsp_valid=1 -> all req_ready=0 and rsp_sum held. rsp_ready=1 together with a pending request -> drain and accept happen in the same cycle.
6. Reset mid-chain: assert rst after a non-last beat with carry=1 -> rsp_valid=0 immediately. After release, a new beat 0x01+0x01 gives 0x02 with add_cin=0.
